field_accumulator: RTL

- Upstream/downstream wrapper around one field_adder: accepts a stream of field elements and produces their modular sum.
- Serialises the additions through the multi-cycle adder (`F_ADD_CYCLES` latency) with a ready/valid input stream and a held result output.
- Used wherever a layer reduction needs sum-of-terms, such as summing partial products from multiplier banks before the next round.

---
 rtl/field_accumulator_pkg.sv | 28 ++
 rtl/field_accumulator_if.sv | 46 ++++
 rtl/field_adder.sv | 62 ++++++
 rtl/field_accumulator.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/field_accumulator_pkg.sv
// field_acc_pkg: shared definitions for the field accumulator slice.
//   acc_state_t    : controller states IDLE / WAIT_IN / ADD / DONE
//   ACC_STATE_BITS : width of the state encoding
// Field parameters (F_NBITS, F_PRIME, F_ADD_CYCLES) normally come from
// field_arith_defs.v; the guarded fallbacks below keep this slice buildable
// on its own and never override an existing definition.
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_PRIME
`define F_PRIME 65521
`endif
`ifndef F_ADD_CYCLES
`define F_ADD_CYCLES 3
`endif

package field_acc_pkg;

  localparam int ACC_STATE_BITS = 2;

  typedef enum logic [ACC_STATE_BITS-1:0] {
    IDLE    = 2'd0,
    WAIT_IN = 2'd1,
    ADD     = 2'd2,
    DONE    = 2'd3
  } acc_state_t;

endpackage

// File: rtl/field_accumulator_if.sv
// field_accumulator_if: input element stream plus held result of the
// field accumulator.
//   in_valid/in_data/in_last/in_ready : element stream (transfer on valid&&ready)
//   out_valid/out_data/out_ready      : accumulated sum, held until taken
//   out_count (FIELD_ACC_COUNT_EN)    : number of elements summed
// Modports: master = stream producer / result consumer, slave = accumulator.
`ifndef F_NBITS
`define F_NBITS 16
`endif

interface field_accumulator_if #(
  parameter int cnt_bits = 16
);

  logic                in_valid;
  logic [`F_NBITS-1:0] in_data;
  logic                in_last;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [`F_NBITS-1:0] out_data;
`ifdef FIELD_ACC_COUNT_EN
  logic [cnt_bits-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
`endif

endinterface

// File: rtl/field_adder.sv
// field_adder: multi-cycle modular adder, c = (a + b) mod F_PRIME.
//   clk, rst_n      : clock, synchronous active-low reset (clears the busy pipe)
//   en              : one-cycle start strobe; a and b are sampled with it
//   a, b            : canonical field operands
//   c               : result, held from the sampling edge until the next en
//   ready_pulse     : one-cycle strobe marking c valid
// The strobe is high in the F_ADD_CYCLES-th cycle counting the en cycle as
// the first one, so F_ADD_CYCLES must be at least 2.
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_PRIME
`define F_PRIME 65521
`endif
`ifndef F_ADD_CYCLES
`define F_ADD_CYCLES 3
`endif

module field_adder (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [`F_NBITS-1:0] a,
  input  logic [`F_NBITS-1:0] b,
  output logic [`F_NBITS-1:0] c,
  output logic                ready_pulse
);

  localparam int             NB    = `F_NBITS;
  localparam int             LAT   = `F_ADD_CYCLES;
  localparam logic [NB:0]    P_EXT = (NB+1)'(`F_PRIME);

  logic [LAT-2:0] busy_p0;
  logic [NB-1:0]  c_p0;

  // Both operands are below the prime, so one conditional subtraction
  // brings the carry-extended sum back into range.
  function automatic logic [NB-1:0] mod_add(input logic [NB-1:0] x,
                                            input logic [NB-1:0] y);
    logic [NB:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= P_EXT) s = s - P_EXT;
    return s[NB-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_p0 <= '0;
    end else begin
      busy_p0[0] <= en;
      for (int i = 1; i < LAT - 1; i++) busy_p0[i] <= busy_p0[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) c_p0 <= mod_add(a, b);
  end

  assign c           = c_p0;
  assign ready_pulse = busy_p0[LAT-2];

endmodule

// File: rtl/field_accumulator.sv
// field_accumulator: sums a ready/valid stream of field elements mod F_PRIME
// through one serially reused field_adder (iadd) and presents the sum as a
// held result.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : in_valid/in_data/in_last/in_ready element stream,
//                     out_valid/out_data/out_ready result hand-off,
//                     out_count when FIELD_ACC_COUNT_EN is defined
// Parameter cnt_bits (>= 2): element counter width; a stream that reaches
// 2^cnt_bits-1 elements without in_last is completed as if it were last.
// Optional feature macro: FIELD_ACC_COUNT_EN (adds bus.out_count).
`ifndef F_NBITS
`define F_NBITS 16
`endif

module field_accumulator
  import field_acc_pkg::*;
#(
  parameter int cnt_bits = 16
) (
  input  logic clk,
  input  logic rst,
  field_accumulator_if.slave bus
);

  localparam int                  NB      = `F_NBITS;
  localparam logic [cnt_bits-1:0] CNT_MAX = '1;
  localparam logic [cnt_bits-1:0] CNT_ONE = {{(cnt_bits-1){1'b0}}, 1'b1};

  acc_state_t          state;
  logic [NB-1:0]       acc;
  logic [NB-1:0]       b_opnd;
  logic [cnt_bits-1:0] counter;
  logic [cnt_bits-1:0] cnt_inc;
  logic                last_pend;
  logic                add_en;
  logic                add_pulse;
  logic [NB-1:0]       add_c;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [NB-1:0]       out_data_r;
`ifdef FIELD_ACC_COUNT_EN
  logic [cnt_bits-1:0] out_count_r;
`endif

  // Reaching the counter ceiling ends the stream instead of wrapping.
  function automatic logic cnt_sat(input logic [cnt_bits-1:0] n);
    return n == CNT_MAX;
  endfunction

  assign cnt_inc = counter + 1'b1;

  field_adder iadd (
    .clk         (clk),
    .rst_n       (~rst),
    .en          (add_en),
    .a           (acc),
    .b           (b_opnd),
    .c           (add_c),
    .ready_pulse (add_pulse)
  );

  // Controller: all handshake outputs are registered from the next state,
  // so in_ready has no combinational path from in_valid. Data registers
  // (acc, b_opnd) are only loaded, never reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      last_pend   <= 1'b0;
      add_en      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
`ifdef FIELD_ACC_COUNT_EN
      out_count_r <= '0;
`endif
    end else begin
      add_en <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (bus.in_valid && in_ready_r) begin
            // First element bypasses the adder.
            acc     <= bus.in_data;
            counter <= CNT_ONE;
            if (bus.in_last || cnt_sat(CNT_ONE)) begin
              state       <= DONE;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              out_data_r  <= bus.in_data;
`ifdef FIELD_ACC_COUNT_EN
              out_count_r <= CNT_ONE;
`endif
            end else begin
              state <= WAIT_IN;
            end
          end
        end
        WAIT_IN: begin
          if (bus.in_valid) begin
            b_opnd     <= bus.in_data;
            last_pend  <= bus.in_last;
            add_en     <= 1'b1;
            in_ready_r <= 1'b0;
            state      <= ADD;
          end
        end
        ADD: begin
          if (add_pulse) begin
            acc     <= add_c;
            counter <= cnt_inc;
            if (last_pend || cnt_sat(cnt_inc)) begin
              state       <= DONE;
              out_valid_r <= 1'b1;
              out_data_r  <= add_c;
`ifdef FIELD_ACC_COUNT_EN
              out_count_r <= cnt_inc;
`endif
            end else begin
              state      <= WAIT_IN;
              in_ready_r <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
`ifdef FIELD_ACC_COUNT_EN
  assign bus.out_count = out_count_r;
`endif

endmodule
